imem_responder: RTL and testbench

- Instruction-memory responder: the memory-side end of the core's instruction-fetch interface.
- Accepts one fetch address at a time over a valid/ready request channel.
- Returns the 32-bit instruction word after a fixed, parameterised latency over a valid/ready response channel.
- Holds a word-addressed instruction store, loaded by the testbench/loader through a separate write port; flags misaligned and out-of-range fetches.

---
 rtl/imem_if.sv | 21 ++
 rtl/imem_responder.sv | 101 ++++++++++
 tb/tb_imem_responder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Fetch request/response channel between an instruction-fetch master and the
// memory-side responder.
interface imem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed-latency response,
// word-addressed store written through a side load port.
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.slave       bus,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        ok_q, ok_d;
    logic [31:0] rd_data_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] req_off, load_off;
    logic        req_fault, load_ok, accept;
    logic        req_ready_c, resp_valid_c;

    // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
    assign req_off   = bus.req_addr - BASE_ADDR;
    assign load_off  = load_addr - BASE_ADDR;
    assign req_fault = (req_off[1:0] != 2'b00) || (req_off[31:AW+2] != '0);
    assign load_ok   = (load_off[1:0] == 2'b00) && (load_off[31:AW+2] == '0);
    assign accept    = (state_q == IDLE) && bus.req_valid;

    // Read-first store: a same-edge load to the fetched word returns the old data.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_q <= mem_q[req_off[AW+1:2]];
        end
        if (load_en && load_ok) begin
            mem_q[load_off[AW+1:2]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        ok_d         = ok_q;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    err_d   = req_fault;
                    ok_d    = !req_fault;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ok_q gates the raw RAM register so faults and reset both present zero.
    assign bus.resp_inst  = ok_q ? rd_data_q : 32'h0;
    assign bus.resp_err   = err_q;
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_imem_responder.sv
// Randomised self-checking bench for imem_responder: a LATENCY=2 and a LATENCY=0
// instance share the load port and reset and are compared against an array model.
module tb_imem_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        busy2, busy0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [DEPTH];

    imem_if bus2 ();
    imem_if bus0 ();

    imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus2), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy2));

    imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy0));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    function automatic void model_read(input logic [31:0] a, output logic [31:0] inst,
                                       output logic err);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00 || off >= DEPTH * 4) begin
            err  = 1'b1;
            inst = 32'h0;
        end else begin
            err  = 1'b0;
            inst = model_mem[off / 4];
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] == 2'b00 && off < DEPTH * 4) model_mem[off / 4] = d;
    endfunction

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_write(a, d);
    endtask

    // mode 0: plain fetch; 1: load to same address during WAIT; 2: same-edge load
    task automatic fetch2(input logic [31:0] a, input int bp, input int mode,
                          input logic [31:0] ld_d, input string tag);
        logic [31:0] ei;
        logic        ee;
        int          cyc;
        model_read(a, ei, ee);
        n_checks++;
        if (bus2.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready_idle got=%b want=1", tag, bus2.req_ready);
        end
        bus2.req_valid = 1'b1; bus2.req_addr = a; bus2.resp_ready = 1'b0;
        if (mode == 2) begin
            load_en = 1'b1; load_addr = a; load_data = ld_d;
        end
        @(posedge clk); #1;
        bus2.req_valid = 1'b0; bus2.req_addr = $urandom;
        if (mode == 2) begin
            load_en = 1'b0; model_write(a, ld_d);
        end
        if (mode == 1) begin
            load_en = 1'b1; load_addr = a; load_data = ld_d;
        end
        cyc = 1;
        while (bus2.resp_valid !== 1'b1 && cyc < 20) begin
            n_checks++;
            if (bus2.req_ready !== 1'b0 || busy2 !== 1'b1) begin
                n_fail++;
                $display("FAIL %s wait_flags req_ready=%b busy=%b want 0/1", tag,
                         bus2.req_ready, busy2);
            end
            @(posedge clk); #1;
            if (load_en) begin
                load_en = 1'b0; model_write(a, ld_d);
            end
            cyc++;
        end
        load_en = 1'b0;
        n_checks++;
        if (cyc != LAT + 1) begin
            n_fail++;
            $display("FAIL %s latency got=%0d want=%0d", tag, cyc, LAT + 1);
        end
        n_checks++;
        if (bus2.resp_inst !== ei || bus2.resp_err !== ee) begin
            n_fail++;
            $display("FAIL %s resp got inst=%h err=%b want inst=%h err=%b", tag,
                     bus2.resp_inst, bus2.resp_err, ei, ee);
        end
        repeat (bp) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus2.resp_valid !== 1'b1 || bus2.resp_inst !== ei || bus2.resp_err !== ee ||
                bus2.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold got v=%b inst=%h err=%b rdy=%b want v=1 inst=%h err=%b rdy=0",
                         tag, bus2.resp_valid, bus2.resp_inst, bus2.resp_err, bus2.req_ready, ei, ee);
            end
        end
        bus2.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.resp_ready = 1'b0;
        n_checks++;
        if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s retire got v=%b rdy=%b busy=%b want 0/1/0", tag,
                     bus2.resp_valid, bus2.req_ready, busy2);
        end
        $display("fetch %s addr=%h inst=%h err=%b lat=%0d bp=%0d mode=%0d", tag, a, ei, ee,
                 cyc, bp, mode);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus2.resp_valid !== 1'b0 || busy2 !== 1'b0 || bus2.resp_inst !== 32'h0 ||
            bus2.resp_err !== 1'b0 || bus0.resp_valid !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b busy=%b inst=%h err=%b v0=%b busy0=%b want zeros",
                     bus2.resp_valid, busy2, bus2.resp_inst, bus2.resp_err, bus0.resp_valid, busy0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus2.req_ready !== 1'b1 || bus0.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b/%b want=1/1", bus2.req_ready, bus0.req_ready);
        end
        $display("reset released");
    endtask

    task automatic test_preload();
        for (int i = 0; i < int'(DEPTH); i++) load_word(BASE + 32'(i * 4), $urandom);
        $display("store preloaded with %0d words", DEPTH);
    endtask

    task automatic test_basic();
        load_word(BASE, 32'h0010_0093);
        load_word(BASE + 32'd4, 32'h0000_0073);
        fetch2(BASE, 0, 0, 32'h0, "basic_w0");
        fetch2(BASE + 32'd4, 0, 0, 32'h0, "basic_w1");
    endtask

    task automatic test_backpressure();
        fetch2(BASE + 32'd8, 5, 0, 32'h0, "backpressure");
    endtask

    task automatic test_faults();
        fetch2(32'h8000_0002, 0, 0, 32'h0, "fault_misaligned");
        fetch2(32'h8000_1000, 0, 0, 32'h0, "fault_above");
        fetch2(32'h7FFF_FFFC, 0, 0, 32'h0, "fault_below");
    endtask

    task automatic test_load_drop();
        load_word(BASE + 32'd6, 32'h1111_1111);
        load_word(BASE + 32'h1000, 32'h2222_2222);
        load_word(BASE - 32'd4, 32'h3333_3333);
        fetch2(BASE + 32'd4, 0, 0, 32'h0, "drop_misaligned");
        fetch2(BASE, 0, 0, 32'h0, "drop_above");
        fetch2(BASE + 32'hFFC, 0, 0, 32'h0, "drop_below");
    endtask

    task automatic test_rw_order();
        fetch2(BASE, 0, 2, 32'hDEAD_BEEF, "same_edge_old");
        fetch2(BASE, 0, 0, 32'h0, "same_edge_new");
        fetch2(BASE + 32'd12, 1, 1, 32'hCAFE_F00D, "load_in_wait");
        fetch2(BASE + 32'd12, 0, 0, 32'h0, "after_wait_load");
    endtask

    task automatic test_reset_midop();
        bus2.req_valid = 1'b1; bus2.req_addr = BASE + 32'd4;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_busy got=%b want=1", busy2);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus2.resp_valid !== 1'b0 || busy2 !== 1'b0 || bus2.resp_inst !== 32'h0 ||
            bus2.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_async got v=%b busy=%b inst=%h err=%b want zeros",
                     bus2.resp_valid, busy2, bus2.resp_inst, bus2.resp_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL midop_noresp cyc=%0d got v=%b rdy=%b want 0/1", i,
                         bus2.resp_valid, bus2.req_ready);
            end
        end
        fetch2(BASE + 32'd4, 0, 0, 32'h0, "after_midop_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          cls;
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 5);
            case (cls)
                0, 1, 2: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
                3:       a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
                4:       a = BASE + 32'h1000 + 32'($urandom_range(0, 255) * 4);
                default: a = BASE - 32'($urandom_range(1, 256) * 4);
            endcase
            if ($urandom_range(0, 3) == 0) load_word(a, $urandom);
            fetch2(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, "random");
        end
    endtask

    task automatic test_lat0_single();
        logic [31:0] ei;
        logic        ee;
        model_read(BASE + 32'd4, ei, ee);
        bus0.req_valid = 1'b1; bus0.req_addr = BASE + 32'd4; bus0.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        n_checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_inst !== ei || bus0.resp_err !== ee) begin
            n_fail++;
            $display("FAIL lat0_resp got v=%b inst=%h err=%b want v=1 inst=%h err=%b",
                     bus0.resp_valid, bus0.resp_inst, bus0.resp_err, ei, ee);
        end
        @(posedge clk); #1;
        bus0.resp_ready = 1'b0;
        n_checks++;
        if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat0_retire got v=%b rdy=%b want 0/1", bus0.resp_valid, bus0.req_ready);
        end
        $display("fetch lat0 addr=%h inst=%h err=%b", BASE + 32'd4, ei, ee);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, ei;
        logic        ee;
        bus0.resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = (i == 7) ? 32'h8000_0001 : BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            model_read(a, ei, ee);
            n_checks++;
            if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle i=%0d got rdy=%b v=%b want 1/0", i, bus0.req_ready,
                         bus0.resp_valid);
            end
            bus0.req_valid = 1'b1; bus0.req_addr = a;
            @(posedge clk); #1;
            bus0.req_addr = $urandom;
            n_checks++;
            if (bus0.resp_valid !== 1'b1 || bus0.resp_inst !== ei || bus0.resp_err !== ee) begin
                n_fail++;
                $display("FAIL b2b_resp i=%0d got v=%b inst=%h err=%b want v=1 inst=%h err=%b", i,
                         bus0.resp_valid, bus0.resp_inst, bus0.resp_err, ei, ee);
            end
            @(posedge clk); #1;
            $display("fetch b2b i=%0d addr=%h inst=%h err=%b", i, a, ei, ee);
        end
        bus0.req_valid = 1'b0; bus0.resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        bus2.req_valid = 1'b0; bus2.req_addr = 32'h0; bus2.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_addr = 32'h0; bus0.resp_ready = 1'b0;
        test_reset();
        test_preload();
        test_basic();
        test_backpressure();
        test_faults();
        test_load_drop();
        test_rw_order();
        test_reset_midop();
        test_random();
        test_lat0_single();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
